// File: rtl/clk_div_multi_if.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_multi_if
// Brief    : Configuration bus for clk_div_multi (write strobe, status back).
// Revision : 1.0 - initial release
// ============================================================================
interface clk_div_multi_if #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 28
);
   localparam int c_CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic                cfg_we;
   logic [c_CH_W-1:0]   cfg_ch;
   logic [CNT_W-1:0]    cfg_half;
   logic                cfg_err;
   logic [NUM_CH-1:0]   cfg_pending;

   modport master (
      output cfg_we, cfg_ch, cfg_half,
      input  cfg_err, cfg_pending
   );

   modport slave (
      input  cfg_we, cfg_ch, cfg_half,
      output cfg_err, cfg_pending
   );
endinterface
`default_nettype wire

// File: rtl/clk_div_multi.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_multi
// Brief    : NUM_CH programmable square-wave dividers of clk100Mhz with
//            rise/fall tick strobes and boundary-aligned half-period updates.
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_multi #(
   parameter int NUM_CH       = 4,
   parameter int CNT_W        = 28,
   parameter int DEFAULT_HALF = 500
) (
   input  wire logic              clk100Mhz,
   input  wire logic              rst_n,
   input  wire logic [NUM_CH-1:0] en,
   input  wire logic              sync_restart,
   clk_div_multi_if.slave         cfg,
   output logic      [NUM_CH-1:0] slow_clk,
   output logic      [NUM_CH-1:0] rise_tick,
   output logic      [NUM_CH-1:0] fall_tick
);

   localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] c_DEFHALF = CNT_W'(DEFAULT_HALF);

   logic w_ch_oob;
   logic w_half_zero;
   logic w_cfg_ok;
   logic r_cfg_err;

   assign w_ch_oob    = (int'(cfg.cfg_ch) >= NUM_CH);
   assign w_half_zero = (cfg.cfg_half == '0);
   assign w_cfg_ok    = cfg.cfg_we && !w_ch_oob && !w_half_zero;

   always_ff @(posedge clk100Mhz) begin
      if (!rst_n) begin
         r_cfg_err <= 1'b0;
      end else begin
         r_cfg_err <= cfg.cfg_we && (w_ch_oob || w_half_zero);
      end
   end

   assign cfg.cfg_err = r_cfg_err;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] r_active;
      logic [CNT_W-1:0] r_shadow;
      logic             r_pending;
      logic             r_slow;
      logic             r_rise;
      logic             r_fall;
      logic             w_wr;
      logic             w_bnd;

      assign w_wr  = w_cfg_ok && (int'(cfg.cfg_ch) == i);
      assign w_bnd = en[i] && (r_cnt == r_active);

      always_ff @(posedge clk100Mhz) begin
         if (!rst_n) begin
            r_cnt     <= c_ONE;
            r_active  <= c_DEFHALF;
            r_shadow  <= c_DEFHALF;
            r_pending <= 1'b0;
            r_slow    <= 1'b0;
            r_rise    <= 1'b0;
            r_fall    <= 1'b0;
         end else if (sync_restart) begin
            // Realign phase; anything pending (or written now) takes effect at once.
            r_cnt     <= c_ONE;
            r_slow    <= 1'b0;
            r_rise    <= 1'b0;
            r_fall    <= 1'b0;
            r_pending <= 1'b0;
            if (w_wr) begin
               r_active <= cfg.cfg_half;
               r_shadow <= cfg.cfg_half;
            end else if (r_pending) begin
               r_active <= r_shadow;
            end
         end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (w_bnd) begin
               r_cnt  <= c_ONE;
               r_slow <= ~r_slow;
               r_rise <= ~r_slow;
               r_fall <= r_slow;
            end else if (en[i]) begin
               r_cnt <= r_cnt + c_ONE;
            end

            // A write landing on the boundary bypasses the shadow stage.
            if (w_bnd) begin
               if (w_wr) begin
                  r_active  <= cfg.cfg_half;
                  r_shadow  <= cfg.cfg_half;
                  r_pending <= 1'b0;
               end else if (r_pending) begin
                  r_active  <= r_shadow;
                  r_pending <= 1'b0;
               end
            end else if (w_wr) begin
               r_shadow  <= cfg.cfg_half;
               r_pending <= 1'b1;
            end
         end
      end

      assign slow_clk[i]        = r_slow;
      assign rise_tick[i]       = r_rise;
      assign fall_tick[i]       = r_fall;
      assign cfg.cfg_pending[i] = r_pending;
   end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_div_multi
// Brief    : Directed scoreboard bench for clk_div_multi (4-ch and 3-ch builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_div_multi;

   logic       clk100Mhz = 1'b0;
   logic       rst_n;
   logic [3:0] en;
   logic       sync_restart;
   logic [3:0] slow_clk, rise_tick, fall_tick;
   logic [2:0] en3;
   logic [2:0] slow3, rise3, fall3;

   always #5 clk100Mhz = ~clk100Mhz;

   clk_div_multi_if #(.NUM_CH(4), .CNT_W(28)) bus ();
   clk_div_multi_if #(.NUM_CH(3), .CNT_W(8))  bus3 ();

   clk_div_multi #(.NUM_CH(4), .CNT_W(28), .DEFAULT_HALF(500)) u_dut (
      .clk100Mhz    (clk100Mhz),
      .rst_n        (rst_n),
      .en           (en),
      .sync_restart (sync_restart),
      .cfg          (bus),
      .slow_clk     (slow_clk),
      .rise_tick    (rise_tick),
      .fall_tick    (fall_tick)
   );

   clk_div_multi #(.NUM_CH(3), .CNT_W(8), .DEFAULT_HALF(5)) u_dut3 (
      .clk100Mhz    (clk100Mhz),
      .rst_n        (rst_n),
      .en           (en3),
      .sync_restart (sync_restart),
      .cfg          (bus3),
      .slow_clk     (slow3),
      .rise_tick    (rise3),
      .fall_tick    (fall3)
   );

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_bad  = 0;
   int   ecount = 0;

   task automatic expect_v(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic check(input logic [31:0] obs);
      exp_t e;
      n_cmp++;
      if (sb.size() == 0) begin
         n_bad++;
         $error("FAIL sb_empty: observed %0h, nothing queued", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic step();
      @(posedge clk100Mhz);
      #1;
      ecount++;
   endtask

   task automatic wait_tick(input int ch, input bit want_rise, input int budget, output int at);
      at = -1;
      for (int k = 0; k < budget; k++) begin
         step();
         if (want_rise ? rise_tick[ch] : fall_tick[ch]) begin
            at = ecount;
            break;
         end
      end
   endtask

   task automatic cfg_write(input logic [1:0] ch, input logic [27:0] half);
      bus.cfg_we   = 1'b1;
      bus.cfg_ch   = ch;
      bus.cfg_half = half;
   endtask

   task automatic run_to(input int target);
      while (ecount < target) step();
   endtask

   initial begin : main
      int at;
      int base;
      int frozen_bad;

      rst_n         = 1'b0;
      en            = 4'h0;
      en3           = 3'b111;
      sync_restart  = 1'b0;
      bus.cfg_we    = 1'b0;
      bus.cfg_ch    = '0;
      bus.cfg_half  = '0;
      bus3.cfg_we   = 1'b0;
      bus3.cfg_ch   = '0;
      bus3.cfg_half = '0;

      // Reset state
      expect_v("rst_slow", 0);
      expect_v("rst_rise", 0);
      expect_v("rst_fall", 0);
      expect_v("rst_err", 0);
      expect_v("rst_pend", 0);
      repeat (3) step();
      check(32'(slow_clk));
      check(32'(rise_tick));
      check(32'(fall_tick));
      check(32'(bus.cfg_err));
      check(32'(bus.cfg_pending));

      // Default divide: rise at 500, fall at 1000, all channels together
      rst_n  = 1'b1;
      en     = 4'hF;
      ecount = 0;
      expect_v("def_rise_at", 500);
      expect_v("def_rise_all", 32'hF);
      expect_v("def_slow_hi", 32'hF);
      wait_tick(0, 1'b1, 2000, at);
      check(32'(at));
      check(32'(rise_tick));
      check(32'(slow_clk));
      expect_v("def_fall_at", 1000);
      expect_v("def_fall_all", 32'hF);
      wait_tick(0, 1'b0, 2000, at);
      check(32'(at));
      check(32'(fall_tick));

      // Ch1 half=3 written at cnt=200, applied at the edge-1500 boundary
      run_to(1199);
      cfg_write(2'd1, 28'd3);
      expect_v("wr_pending", 32'b0010);
      step();
      bus.cfg_we = 1'b0;
      check(32'(bus.cfg_pending));
      expect_v("ch1_rise_at", 1500);
      expect_v("bnd_rise_all", 32'hF);
      expect_v("bnd_pend_clr", 0);
      wait_tick(1, 1'b1, 2000, at);
      check(32'(at));
      check(32'(rise_tick));
      check(32'(bus.cfg_pending));
      expect_v("ch1_fall_at", 1503);
      expect_v("ch1_fall_only", 32'b0010);
      wait_tick(1, 1'b0, 100, at);
      check(32'(at));
      check(32'(fall_tick));
      expect_v("ch1_rise2_at", 1506);
      wait_tick(1, 1'b1, 100, at);
      check(32'(at));

      // Rejected writes: zero half, and channel index out of range on 3-ch build
      cfg_write(2'd2, 28'd0);
      bus3.cfg_we   = 1'b1;
      bus3.cfg_ch   = 2'd3;
      bus3.cfg_half = 8'd7;
      expect_v("err_zero", 1);
      expect_v("err_zero_pend", 0);
      expect_v("err_oob", 1);
      expect_v("err_oob_pend", 0);
      step();
      bus.cfg_we  = 1'b0;
      bus3.cfg_we = 1'b0;
      check(32'(bus.cfg_err));
      check(32'(bus.cfg_pending));
      check(32'(bus3.cfg_err));
      check(32'(bus3.cfg_pending));
      expect_v("err_one_cycle", 0);
      step();
      check(32'(bus.cfg_err));

      // Freeze ch2 for 50 cycles mid-half: its fall moves from 2000 to 2050
      run_to(1700);
      en = 4'b1011;
      frozen_bad = 0;
      for (int k = 0; k < 50; k++) begin
         step();
         if (rise_tick[2] || fall_tick[2] || !slow_clk[2]) frozen_bad++;
      end
      en = 4'hF;
      expect_v("ch2_frozen", 0);
      check(32'(frozen_bad));
      expect_v("ch2_fall_at", 2050);
      wait_tick(2, 1'b0, 1000, at);
      check(32'(at));

      // sync_restart with ch0 pending half=10 and a same-cycle write ch3 half=1
      run_to(2060);
      cfg_write(2'd0, 28'd10);
      expect_v("ch0_pending", 32'b0001);
      step();
      bus.cfg_we = 1'b0;
      check(32'(bus.cfg_pending));
      run_to(2070);
      sync_restart = 1'b1;
      cfg_write(2'd3, 28'd1);
      expect_v("rs_slow", 0);
      expect_v("rs_rise", 0);
      expect_v("rs_fall", 0);
      expect_v("rs_pend", 0);
      step();
      sync_restart = 1'b0;
      bus.cfg_we   = 1'b0;
      base         = ecount;
      check(32'(slow_clk));
      check(32'(rise_tick));
      check(32'(fall_tick));
      check(32'(bus.cfg_pending));
      expect_v("rs_ch3_first", 32'b1000);
      step();
      check(32'(rise_tick));
      expect_v("rs_ch0_at", 32'(base + 10));
      expect_v("rs_ch0_only", 32'b0001);
      wait_tick(0, 1'b1, 100, at);
      check(32'(at));
      check(32'(rise_tick));

      // One-cycle reset with a concurrent write: write lost, defaults restored
      rst_n = 1'b0;
      cfg_write(2'd1, 28'd7);
      expect_v("mr_slow", 0);
      expect_v("mr_rise", 0);
      expect_v("mr_fall", 0);
      expect_v("mr_pend", 0);
      expect_v("mr_err", 0);
      step();
      rst_n      = 1'b1;
      bus.cfg_we = 1'b0;
      base       = ecount;
      check(32'(slow_clk));
      check(32'(rise_tick));
      check(32'(fall_tick));
      check(32'(bus.cfg_pending));
      check(32'(bus.cfg_err));
      expect_v("mr_ch1_at", 32'(base + 500));
      expect_v("mr_rise_all", 32'hF);
      wait_tick(1, 1'b1, 1000, at);
      check(32'(at));
      check(32'(rise_tick));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
